// File: rtl/vga_layer_engine.sv
// Layered Sierpinski-stripe renderer: 2-stage pixel pipeline with delay-matched syncs
// and a vsync-edge-driven frame counter. Define VGA_LAYER_PALETTE_EN for the 8-entry palette.
module vga_layer_engine #(
  parameter int   LAYERS      = 32,
  parameter int   LAYER_STEP  = 2,
  parameter int   PHASE_BITS  = 5,
  parameter int   FRAME_BITS  = 10,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            hpos,
  input  logic [9:0]            vpos,
  input  logic                  display_on,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  pause,
  input  logic                  step,
  input  logic                  reverse,
  input  logic [1:0]            speed,
  output logic [1:0]            r_out,
  output logic [1:0]            g_out,
  output logic [1:0]            b_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic [FRAME_BITS-1:0] frame
);

  logic [FRAME_BITS-1:0] frame_reg, frame_next, inc;
  logic                  pending_reg, pending_next;
  logic                  vsync_edge_reg, step_reg;
  logic                  vs_edge, step_rise, pend_eff;
  logic [PHASE_BITS-1:0] t;
  logic [LAYERS-1:0]     hit, hit_reg;
  logic                  disp_reg, hs_reg, vs_reg;
  logic [5:0]            c, rgb_col, rgb_next, rgb_reg;
  logic                  hs_out_reg, vs_out_reg;

  assign t = frame_reg[PHASE_BITS-1:0];

  // A step edge arriving together with the vsync edge is folded in before the edge consumes it.
  always_comb begin
    vs_edge      = (vsync_in == SYNC_ACTIVE) && (vsync_edge_reg != SYNC_ACTIVE);
    step_rise    = step && !step_reg;
    inc          = FRAME_BITS'(1) << speed;
    pend_eff     = pending_reg | (pause & step_rise);
    frame_next   = frame_reg;
    pending_next = pend_eff;
    if (vs_edge && (!pause || pend_eff)) begin
      frame_next = reverse ? frame_reg - inc : frame_reg + inc;
      if (pause) pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_reg      <= '0;
      pending_reg    <= 1'b0;
      vsync_edge_reg <= ~SYNC_ACTIVE;
      step_reg       <= 1'b0;
    end else begin
      frame_reg      <= frame_next;
      pending_reg    <= pending_next;
      vsync_edge_reg <= vsync_in;
      step_reg       <= step;
    end
  end

  // Only xo[7:5] and yo[8:0] feed the hit test, so the casts keep just those bits.
  genvar gi;
  generate
    for (gi = 0; gi < LAYERS; gi++) begin : g_layer
      localparam int          I = gi * LAYER_STEP;
      localparam logic [19:0] D = 20'(256 - I);
      logic [2:0] xo_band;
      logic [8:0] yo_low;
      assign xo_band = 3'(((20'(hpos) + ((20'(t) * 20'(I + 32)) >> 3)) * D) >> 12);
      assign yo_low  = 9'(((20'(vpos) + ((20'(t) * 20'(I)) >> 3)) * D) >> 7);
      assign hit[gi] = ((yo_low & 9'(I * 8)) == 9'd0) && (xo_band == 3'd0);
    end
  endgenerate

  always_comb begin
    c = hit_reg[0] ? 6'd1 : 6'd0;
    for (int k = 1; k < LAYERS; k++) begin
      if (hit_reg[k]) c = 6'(k * LAYER_STEP);
    end
`ifdef VGA_LAYER_PALETTE_EN
    if (c == 6'd0)      rgb_col = 6'd0;
    else if (c == 6'd1) rgb_col = 6'b000011;
    else                rgb_col = {c[5], c[5], c[4:3], ~c[4:3]};
`else
    rgb_col = c;
`endif
    rgb_next = disp_reg ? rgb_col : 6'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_reg    <= '0;
      disp_reg   <= 1'b0;
      hs_reg     <= ~SYNC_ACTIVE;
      vs_reg     <= ~SYNC_ACTIVE;
      rgb_reg    <= 6'd0;
      hs_out_reg <= ~SYNC_ACTIVE;
      vs_out_reg <= ~SYNC_ACTIVE;
    end else begin
      hit_reg    <= hit;
      disp_reg   <= display_on;
      hs_reg     <= hsync_in;
      vs_reg     <= vsync_in;
      rgb_reg    <= rgb_next;
      hs_out_reg <= hs_reg;
      vs_out_reg <= vs_reg;
    end
  end

  assign {r_out, g_out, b_out} = rgb_reg;
  assign hsync_out = hs_out_reg;
  assign vsync_out = vs_out_reg;
  assign frame     = frame_reg;

endmodule

// File: doc/vga_layer_engine.md
# vga_layer_engine

- Parametrised, fully clocked successor to the single-pattern VGA demo renderer.
- Sits between `hvsync_generator` and the TinyVGA PMOD output mapping. It evaluates LAYERS scrolling Sierpinski-stripe layers per pixel, picks the top visible layer, and emits registered 2-bit-per-channel RGB with sync signals delay-matched to the pixel pipeline.
- Animation runs from an internal frame counter clocked by `clk`. It advances on a detected vsync edge, not on a vsync clock, and supports pause, single-step, reverse and speed control.

## Interface
Parameters:
- LAYERS, 32, number of layers; layer k uses index i = k*LAYER_STEP; LAYERS*LAYER_STEP must be ≤ 64
- LAYER_STEP, 2, index spacing between layers
- PHASE_BITS, 5, frame-counter bits used as scroll phase t
- FRAME_BITS, 10, frame counter width (≥ PHASE_BITS)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hpos  in  10  pixel x from hvsync generator
- vpos  in  10  pixel y
- display_on  in  1  active-video flag
- hsync_in  in  1  raw hsync
- vsync_in  in  1  raw vsync
- pause  in  1  hold frame counter
- step  in  1  rising edge advances one increment while paused
- reverse  in  1  counter decrements instead of increments
- speed  in  2  increment = 1 << speed
- r_out, g_out, b_out  out  2 each  pixel colour
- hsync_out, vsync_out  out  1  syncs delayed to match colour
- frame  out  FRAME_BITS  current frame counter

## Operation
- Frame counter F:
  - Vsync edge = vsync_in transitions to SYNC_ACTIVE; detected with one registered copy of vsync_in.
  - On the edge with pause=0: F ← F ± (1<<speed), modulo 2^FRAME_BITS. Sign is − when reverse=1.
  - A step rising edge is captured into a pending flag.
  - When pause=1, the next vsync edge applies one increment if pending is set, then clears pending.
  - A step edge with pause=0 is ignored and not latched.
- Per layer k, with i = k*LAYER_STEP, d = 256−i, t = F[PHASE_BITS-1:0]:
  - xo = (((hpos + ((t*(i+32))>>3)) * d) >> 7) truncated to 10 bits
  - yo = (((vpos + ((t*i)>>3)) * d) >> 7) truncated to 10 bits
  - Intermediate sums and products are at least 18 bits wide; truncation is applied only at the final 10 bits.
  - hit_k = ((yo[8:0] & (i*8)) == 0) && (xo[7:5] == 0)
- Colour code c, 6 bits:
  - Highest k with hit_k=1 and k>0: c = i.
  - Else, if hit_0=1: c = 1.
  - Else: c = 0.
- Output colour {R,G,B} = display_on_d ? colour(c) : 0.

## Timing
- Stage 1 (edge 1): register the hit vector, display_on, hsync_in and vsync_in.
- Stage 2 (edge 2): priority-encode, apply palette and blanking; register RGB and syncs.
- Latency from hpos/vpos/sync inputs to outputs is exactly 2 clocks. Syncs and colour stay aligned.
- Frame counter update:
  - F changes on the clock after the edge-detect register sees the vsync edge.
  - Pixels already in the pipeline use the t they were stage-1 registered with.
- Reset (async assert, sync release):
  - F=0, pending=0, all RGB=0.
  - hsync_out, vsync_out and the internal sync copies are set to ~SYNC_ACTIVE.
  - The edge detector is set to ~SYNC_ACTIVE, so a vsync already asserted at release counts as an edge.
- Reset mid-frame: outputs go black and inactive immediately; there are no partial-pipeline outputs after release.
- Wrap-around: F increments from 2^FRAME_BITS−1 to 0 and decrements from 0 to all-ones; t wraps with F.
- Vsync edge and step edge in the same cycle while paused: the step is latched first and consumed by that same edge (one increment).

## Configuration
- VGA_LAYER_PALETTE_EN defined:
  - colour(c) = palette of n = c[5:3]: R = {n[2],n[2]}, G = n[1:0], B = ~n[1:0].
  - c=0 still gives black.
  - c=1 gives {R,G,B} = 6'b000011.
- Undefined: colour(c) = c[5:0] directly as {R[1:0],G[1:0],B[1:0]}.

## Test plan
- Reset asserted mid-line with SYNC_ACTIVE=0 → RGB=0, hsync_out=vsync_out=1, frame=0 within the same cycle. After release, hsync_out tracks hsync_in delayed 2 clocks.
- F=0, hpos=0, vpos=0, display_on=1, palette off → c = 62 (top layer k=31 hits), RGB=6'b111110 two clocks later.
- display_on=0 with any position → RGB=0 at latency 2.
- 3 vsync pulses with speed=2, reverse=0 → frame=12. Then reverse=1, 4 pulses → frame=1020 (wrap, FRAME_BITS=10).
- pause=1, 3 vsync pulses → frame unchanged. Then one step pulse followed by 2 vsync pulses → frame advances exactly one increment.
- Palette on, c=62 (n=7) → RGB=6'b111100. A pixel with no layer hit → 0.
